// File: rtl/he_pkg.sv
// Shared definitions for the histogram-equalizer pipeline: frame-source state
// encoding, default image geometry and pixel width.
package he_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } he_state_e;

    localparam int HE_IMAGE_WIDTH  = 660;
    localparam int HE_IMAGE_HEIGHT = 440;
    localparam int HE_ADDR_W       = 19;
    localparam int HE_PIX_W        = 8;

    function automatic int he_frame_pixels(input int width, input int height);
        return width * height;
    endfunction

endpackage

// File: rtl/he_skid_fifo.sv
// Two-entry FIFO between the frame-memory read port and the pixel stream.
// Exposes its occupancy so the reader can throttle requests by credit.
module he_skid_fifo
    import he_pkg::*;
#(
    parameter int WIDTH = HE_PIX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full buffer is only legal when the head leaves the same cycle.
    assign do_pop  = pop_i & (count_q != 2'd0);
    assign do_push = push_i & ((count_q != 2'd2) | do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/he_pixel_source.sv
// Streams one frame from a synchronous frame memory (1-cycle read latency) in
// raster order, tagging start-of-frame, end-of-line and end-of-frame.
module he_pixel_source
    import he_pkg::*;
#(
    parameter int IMAGE_WIDTH  = HE_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = HE_IMAGE_HEIGHT,
    parameter int ADDR_W       = HE_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              pix_eof,
    output logic              busy,
    output logic              frame_done,
    output he_state_e         dbg_state
);

    localparam int NPIX = he_frame_pixels(IMAGE_WIDTH, IMAGE_HEIGHT);
    localparam int XW   = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam int YW   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [XW-1:0]     X_LAST    = XW'(IMAGE_WIDTH - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(IMAGE_HEIGHT - 1);

    he_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic              inflight_q;

    logic [7:0]        fifo_head;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic              xfer;
    logic [2:0]        credit_level;
    logic              rd_ok;

    // Handshake: a pixel moves when pix_valid & pix_ready are both high at a
    // rising edge; while pix_valid is high and pix_ready low, pix_data and the
    // sof/eol/eof tags hold, and pix_valid never drops without a transfer.
    assign xfer = pix_valid & pix_ready;

    he_skid_fifo #(
        .WIDTH(8)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (inflight_q),
        .push_data_i(mem_rdata),
        .pop_i      (xfer),
        .head_o     (fifo_head),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    // The pixel leaving this cycle frees its slot, which keeps the stream at
    // one pixel per cycle while never letting returned data find a full buffer.
    assign credit_level = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, xfer};
    assign rd_ok        = (credit_level < 3'd2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            x_q        <= '0;
            y_q        <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            inflight_q <= mem_rd;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        x_d        = x_q;
        y_d        = y_q;
        mem_rd     = 1'b0;
        frame_done = 1'b0;

        if (xfer) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_STREAM;
                    addr_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                end
            end
            ST_STREAM: begin
                if (rd_ok) begin
                    mem_rd = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    if (addr_q == LAST_ADDR) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (xfer && pix_eof) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem_addr  = addr_q;
    assign pix_valid = ~fifo_empty;
    assign pix_data  = pix_valid ? fifo_head : 8'd0;
    assign pix_sof   = pix_valid & (x_q == '0) & (y_q == '0);
    assign pix_eol   = pix_valid & (x_q == X_LAST);
    assign pix_eof   = pix_eol & (y_q == Y_LAST);
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_he_pixel_source.sv
// Bench for he_pixel_source: a 4x2 instance under directed ready patterns and
// a 66x44 instance run as a full raster with pix_ready held high.
module tb_he_pixel_source;
    import he_pkg::*;

    localparam int SW = 4;
    localparam int SH = 2;
    localparam int SN = SW * SH;
    localparam int BW = 66;
    localparam int BH = 44;
    localparam int BN = BW * BH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- small DUT ----------------
    logic        s_start, s_mem_rd, s_pix_valid, s_pix_ready;
    logic        s_pix_sof, s_pix_eol, s_pix_eof, s_busy, s_frame_done;
    logic [18:0] s_mem_addr;
    logic [7:0]  s_mem_rdata, s_pix_data;
    he_state_e   s_state;

    he_pixel_source #(.IMAGE_WIDTH(SW), .IMAGE_HEIGHT(SH), .ADDR_W(19)) u_small (
        .clk(clk), .reset(reset), .start(s_start),
        .mem_rd(s_mem_rd), .mem_addr(s_mem_addr), .mem_rdata(s_mem_rdata),
        .pix_data(s_pix_data), .pix_valid(s_pix_valid), .pix_ready(s_pix_ready),
        .pix_sof(s_pix_sof), .pix_eol(s_pix_eol), .pix_eof(s_pix_eof),
        .busy(s_busy), .frame_done(s_frame_done), .dbg_state(s_state)
    );

    // ---------------- large DUT ----------------
    logic        b_start, b_mem_rd, b_pix_valid, b_pix_ready;
    logic        b_pix_sof, b_pix_eol, b_pix_eof, b_busy, b_frame_done;
    logic [18:0] b_mem_addr;
    logic [7:0]  b_mem_rdata, b_pix_data;
    he_state_e   b_state;

    he_pixel_source #(.IMAGE_WIDTH(BW), .IMAGE_HEIGHT(BH), .ADDR_W(19)) u_big (
        .clk(clk), .reset(reset), .start(b_start),
        .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_rdata(b_mem_rdata),
        .pix_data(b_pix_data), .pix_valid(b_pix_valid), .pix_ready(b_pix_ready),
        .pix_sof(b_pix_sof), .pix_eol(b_pix_eol), .pix_eof(b_pix_eof),
        .busy(b_busy), .frame_done(b_frame_done), .dbg_state(b_state)
    );

    // Frame memory holds its own index; 0xA5 marks cycles with no read.
    always @(posedge clk) begin
        s_mem_rdata <= s_mem_rd ? s_mem_addr[7:0] : 8'hA5;
        b_mem_rdata <= b_mem_rd ? b_mem_addr[7:0] : 8'hA5;
    end

    // ---------------- scoreboard ----------------
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [10:0] exp_q[$];
    logic [10:0] exp_beat;
    bit          chk_en = 1'b0;
    int          xfer_cnt, rd_cnt, eol_cnt, eof_cnt;
    logic [18:0] exp_addr;
    bit          prev_hold = 1'b0;
    logic [7:0]  prev_data;

    // Expected beats straight from the raster definition: pixel i sits at
    // column i%W, row i/W, and memory returns i.
    task automatic load_model();
        exp_q.delete();
        for (int i = 0; i < SN; i++) begin
            exp_q.push_back({(i == 0), ((i % SW) == SW - 1), (i == SN - 1), 8'(i)});
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && !reset) begin
            if (prev_hold) begin
                check("hold_valid", 32'(s_pix_valid), 32'd1);
                check("hold_data", 32'(s_pix_data), 32'(prev_data));
            end
            if (!s_pix_valid) begin
                check("flags_idle", 32'({s_pix_sof, s_pix_eol, s_pix_eof}), 32'd0);
            end
            if (s_mem_rd) begin
                check("rd_addr", 32'(s_mem_addr), 32'(exp_addr));
                exp_addr++;
                rd_cnt++;
            end
            if (s_pix_valid && s_pix_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL extra_xfer: got data 0x%0h expected no transfer", s_pix_data);
                end else begin
                    exp_beat = exp_q.pop_front();
                    check("beat", 32'({s_pix_sof, s_pix_eol, s_pix_eof, s_pix_data}), 32'(exp_beat));
                end
                xfer_cnt++;
                eol_cnt += int'(s_pix_eol);
                eof_cnt += int'(s_pix_eof);
            end
            prev_hold = s_pix_valid && !s_pix_ready;
            prev_data = s_pix_data;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic arm_model();
        load_model();
        exp_addr = '0;
        rd_cnt   = 0;
        xfer_cnt = 0;
        eol_cnt  = 0;
        eof_cnt  = 0;
        chk_en   = 1'b1;
    endtask

    // mode 0: ready=1; 1: ready toggles 1,0,...; 2: ready=0 for 10 cycles;
    // 3: ready=1 with an extra start pulse mid-stream. Cycle n=0 is the
    // cycle right after the edge that accepted start.
    task automatic run_small(input int mode, output int first_valid_n, output int done_n,
                             output int done_pulses, output int early_rd, output int zero_bad);
        arm_model();
        @(posedge clk); #1;
        s_start     = 1'b1;
        s_pix_ready = 1'b0;
        @(posedge clk); #1;
        s_start       = 1'b0;
        first_valid_n = -1;
        done_n        = -1;
        done_pulses   = 0;
        early_rd      = 0;
        zero_bad      = 0;
        for (int n = 0; n < 200; n++) begin
            case (mode)
                1:       s_pix_ready = ((n % 2) == 0);
                2:       s_pix_ready = (n >= 10);
                default: s_pix_ready = 1'b1;
            endcase
            s_start = (mode == 3) && (n == 4);
            @(negedge clk);
            if (s_pix_valid && first_valid_n < 0) first_valid_n = n;
            if (s_frame_done) begin
                done_pulses++;
                if (done_n < 0) done_n = n;
            end
            if (mode == 2 && n < 10) begin
                early_rd += int'(s_mem_rd);
                if (s_pix_data !== 8'd0) zero_bad++;
            end
            if (done_n >= 0 && n >= done_n + 4) break;
            @(posedge clk); #1;
        end
        s_start = 1'b0;
        check("frame_done_seen", 32'(done_n >= 0), 32'd1);
        check("xfer_total", 32'(xfer_cnt), 32'(SN));
        check("rd_total", 32'(rd_cnt), 32'(SN));
        check("model_drained", 32'(exp_q.size()), 32'd0);
        check("eol_total", 32'(eol_cnt), 32'd2);
        check("eof_total", 32'(eof_cnt), 32'd1);
        check("done_pulses", 32'(done_pulses), 32'd1);
        check("busy_after", 32'(s_busy), 32'd0);
    endtask

    task automatic check_small_reset_values(input string tag);
        check({tag, "_mem_rd"}, 32'(s_mem_rd), 32'd0);
        check({tag, "_mem_addr"}, 32'(s_mem_addr), 32'd0);
        check({tag, "_pix_valid"}, 32'(s_pix_valid), 32'd0);
        check({tag, "_pix_data"}, 32'(s_pix_data), 32'd0);
        check({tag, "_flags"}, 32'({s_pix_sof, s_pix_eol, s_pix_eof}), 32'd0);
        check({tag, "_busy"}, 32'(s_busy), 32'd0);
        check({tag, "_frame_done"}, 32'(s_frame_done), 32'd0);
        check({tag, "_state"}, 32'(s_state), 32'(ST_IDLE));
    endtask

    task automatic run_big();
        int nx, sof_c, eol_c, eof_c, bad, done_n, done_c;
        nx = 0; sof_c = 0; eol_c = 0; eof_c = 0; bad = 0; done_n = -1; done_c = 0;
        @(posedge clk); #1;
        b_start = 1'b1;
        @(posedge clk); #1;
        b_start = 1'b0;
        for (int n = 0; n < BN + 50; n++) begin
            @(negedge clk);
            if (b_pix_valid) begin
                if (b_pix_data !== 8'(nx)) bad++;
                if (b_pix_eol !== ((nx % BW) == BW - 1)) bad++;
                if (b_pix_eof !== (nx == BN - 1)) bad++;
                if (b_pix_sof !== (nx == 0)) bad++;
                sof_c += int'(b_pix_sof);
                eol_c += int'(b_pix_eol);
                eof_c += int'(b_pix_eof);
                nx++;
            end
            if (b_frame_done) begin
                done_c++;
                if (done_n < 0) done_n = n;
            end
            @(posedge clk); #1;
        end
        check("big_xfers", 32'(nx), 32'd2904);
        check("big_pixel_errors", 32'(bad), 32'd0);
        check("big_sof", 32'(sof_c), 32'd1);
        check("big_eol", 32'(eol_c), 32'd44);
        check("big_eof", 32'(eof_c), 32'd1);
        check("big_done_cycle", 32'(done_n), 32'd2906);
        check("big_done_pulses", 32'(done_c), 32'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int fv, dn, dp, er, zb;
        reset       = 1'b1;
        s_start     = 1'b0;
        s_pix_ready = 1'b0;
        b_start     = 1'b0;
        b_pix_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_small_reset_values("por");
        check("por_big_valid", 32'(b_pix_valid), 32'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Full-rate frame: data 0..7 on n=2..9, frame_done at n=10.
        run_small(0, fv, dn, dp, er, zb);
        check("r1_first_valid", 32'(fv), 32'd2);
        check("r1_done_cycle", 32'(dn), 32'd10);

        // Ready 1,0,1,0: transfers on even n from 2 to 16, done at 17.
        run_small(1, fv, dn, dp, er, zb);
        check("tog_first_valid", 32'(fv), 32'd2);
        check("tog_done_cycle", 32'(dn), 32'd17);

        // Ready held low: only two reads outstanding, zero pixel held.
        run_small(2, fv, dn, dp, er, zb);
        check("stall_reads", 32'(er), 32'd2);
        check("stall_zero_data", 32'(zb), 32'd0);
        check("stall_done_cycle", 32'(dn), 32'd18);

        // Start during STREAM is ignored.
        run_small(3, fv, dn, dp, er, zb);
        check("restart_done_cycle", 32'(dn), 32'd10);

        // Reset after three transfers, then a fresh frame from address 0.
        arm_model();
        @(posedge clk); #1;
        s_start     = 1'b1;
        s_pix_ready = 1'b1;
        @(posedge clk); #1;
        s_start = 1'b0;
        for (int n = 0; n < 50 && xfer_cnt < 3; n++) begin
            @(posedge clk); #1;
        end
        check("pre_reset_xfers", 32'(xfer_cnt), 32'd3);
        reset  = 1'b1;
        chk_en = 1'b0;
        #1;
        check_small_reset_values("mid");
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("drop_inflight_valid", 32'(s_pix_valid), 32'd0);
        check("drop_state", 32'(s_state), 32'(ST_IDLE));
        run_small(0, fv, dn, dp, er, zb);
        check("post_reset_done_cycle", 32'(dn), 32'd10);
        chk_en = 1'b0;

        // Long raster on the 66x44 instance.
        run_big();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/he_pixel_source.md
HE_PIXEL_SOURCE -- requirements
Module: he_pixel_source

Interface
REQ-001 SHALL have parameter IMAGE_WIDTH, default 660, pixels per line.
REQ-002 SHALL have parameter IMAGE_HEIGHT, default 440, lines per frame.
REQ-003 SHALL have parameter ADDR_W, default 19, frame-memory address width; must satisfy 2^ADDR_W >= IMAGE_WIDTH*IMAGE_HEIGHT.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle frame-start request.
REQ-007 SHALL have port mem_rd  output  1  frame-memory read strobe.
REQ-008 SHALL have port mem_addr  output  ADDR_W  frame-memory read address, raster order.
REQ-009 SHALL have port mem_rdata  input  8  read data, valid exactly one cycle after mem_rd.
REQ-010 SHALL have port pix_data  output  8  pixel to the histogram-equalizer input.
REQ-011 SHALL have port pix_valid  output  1  pix_data valid.
REQ-012 SHALL have port pix_ready  input  1  downstream accepts; transfer = pix_valid & pix_ready.
REQ-013 SHALL have port pix_sof  output  1  qualifies the first pixel of the frame.
REQ-014 SHALL have port pix_eol  output  1  qualifies the last pixel of each line.
REQ-015 SHALL have port pix_eof  output  1  qualifies the last pixel of the frame.
REQ-016 SHALL have port busy  output  1  high from start acceptance until frame_done.
REQ-017 SHALL have port frame_done  output  1  one-cycle pulse after the final transfer.

Function
REQ-018 SHALL implement states IDLE, STREAM, DRAIN, DONE.
REQ-019 SHALL leave IDLE for STREAM when start=1; read address and pixel counters cleared to 0.
REQ-020 SHALL ignore start in every state except IDLE.
REQ-021 SHALL, in STREAM, assert mem_rd combinationally when (buffer occupancy + reads in flight) < 2, then increment mem_addr.
REQ-022 SHALL enter DRAIN after issuing the read for address IMAGE_WIDTH*IMAGE_HEIGHT-1; no further mem_rd in DRAIN.
REQ-023 SHALL capture mem_rdata into a 2-entry FIFO the cycle after each mem_rd; the FIFO never overflows.
REQ-024 SHALL drive pix_valid = FIFO not empty, pix_data = FIFO head; pix_data stable while pix_valid=1 and pix_ready=0.
REQ-025 SHALL sustain one transfer per cycle with pix_ready held high; first pix_valid two cycles after the start edge.
REQ-026 SHALL track output column x (0..IMAGE_WIDTH-1) and row y, advancing on transfer; x wraps to 0 and y increments at line end.
REQ-027 SHALL derive pix_sof = (x==0 & y==0), pix_eol = (x==IMAGE_WIDTH-1), pix_eof = pix_eol & (y==IMAGE_HEIGHT-1), all gated by pix_valid.
REQ-028 SHALL move DRAIN -> DONE on the transfer carrying pix_eof; DONE pulses frame_done for one cycle, then IDLE.
REQ-029 SHALL accept a start in the cycle immediately following DONE (back-to-back frames).
REQ-030 SHALL never emit more or fewer than IMAGE_WIDTH*IMAGE_HEIGHT transfers per frame regardless of pix_ready pattern.

Reset
REQ-031 SHALL on reset force state IDLE; mem_rd=0, mem_addr=0, pix_valid=0, pix_data=0, sof/eol/eof=0, busy=0, frame_done=0.
REQ-032 SHALL on reset mid-frame discard FIFO contents and any in-flight read; returned data the following cycle is dropped.

Structure
REQ-033 SHALL place state encoding and default image dimensions in shared package he_pkg, reused by the equalizer.
REQ-034 SHALL implement the 2-entry buffer as sub-module he_skid_fifo (parameterised width, depth 2, count output).

Verification
REQ-035 SHALL cover: 4x2 frame, memory = index, pix_ready=1 -> 8 transfers data 0..7 on consecutive cycles, sof on 0, eol on 3 and 7, eof on 7, frame_done one cycle after data 7.
REQ-036 SHALL cover: 4x2 frame, pix_ready toggling 1,0,1,0 -> same data order, pix_data held during ready=0, exactly 8 transfers, no extra mem_rd.
REQ-037 SHALL cover: pix_ready=0 for 10 cycles after start -> at most 2 mem_rd issued, pix_data=0 held, then 8 correct transfers.
REQ-038 SHALL cover: start pulsed during STREAM -> ignored, address sequence unbroken, single frame_done.
REQ-039 SHALL cover: reset asserted after 3 transfers -> all outputs at reset values next cycle; new start restarts at address 0 with sof.
REQ-040 SHALL cover: default 660x440 frame, pix_ready=1 -> 290400 transfers, eol count 440, single eof, frame_done at cycle 290402 after start.
